// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue.
// Holds fetched PC, instruction and TLB fetch flags in order; flushable.
module fetch_inst_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             expFlush,
    input  logic             inValid,
    input  logic [31:0]      inPc,
    input  logic [31:0]      inInstr,
    input  logic             inInstMiss,
    input  logic             inInstIllegal,
    input  logic             inInstInvalid,
    output logic             inReady,
    output logic             outValid,
    output logic [31:0]      outPc,
    output logic [31:0]      outInstr,
    output logic             outInstMiss,
    output logic             outInstIllegal,
    output logic             outInstInvalid,
    input  logic             outReady,
    output logic [CNT_W-1:0] count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        miss;
        logic        illegal;
        logic        invalid;
    } entry_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign inReady  = (count != FULL);
    assign outValid = (count != '0);
    assign push     = inValid & inReady & ~expFlush;
    assign pop      = outValid & outReady & ~expFlush;

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (expFlush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: inPc, instr: inInstr, miss: inInstMiss,
                             illegal: inInstIllegal, invalid: inInstInvalid};
        end
    end

    // Head presentation; an empty queue shows an all-zero NOP to decode.
    always_comb begin
        head = '0;
        if (outValid) head = mem[rd_ptr];
    end

    assign outPc          = head.pc;
    assign outInstr       = head.instr;
    assign outInstMiss    = head.miss;
    assign outInstIllegal = head.illegal;
    assign outInstInvalid = head.invalid;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Testbench for fetch_inst_queue.
// Directed stimulus feeds an expected-entry queue; a monitor checks pops.
module tb_fetch_inst_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             resetn;
    logic             expFlush;
    logic             inValid;
    logic [31:0]      inPc;
    logic [31:0]      inInstr;
    logic             inInstMiss;
    logic             inInstIllegal;
    logic             inInstInvalid;
    logic             inReady;
    logic             outValid;
    logic [31:0]      outPc;
    logic [31:0]      outInstr;
    logic             outInstMiss;
    logic             outInstIllegal;
    logic             outInstInvalid;
    logic             outReady;
    logic [CNT_W-1:0] count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  flags;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .resetn(resetn),
        .expFlush(expFlush),
        .inValid(inValid),
        .inPc(inPc),
        .inInstr(inInstr),
        .inInstMiss(inInstMiss),
        .inInstIllegal(inInstIllegal),
        .inInstInvalid(inInstInvalid),
        .inReady(inReady),
        .outValid(outValid),
        .outPc(outPc),
        .outInstr(outInstr),
        .outInstMiss(outInstMiss),
        .outInstIllegal(outInstIllegal),
        .outInstInvalid(outInstInvalid),
        .outReady(outReady),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every real pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && outValid && outReady && !expFlush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", outPc);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("pop_pc", outPc, e.pc);
                chk("pop_instr", outInstr, e.instr);
                chk("pop_flags",
                    {29'd0, outInstMiss, outInstIllegal, outInstInvalid},
                    {29'd0, e.flags});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [2:0] f, input bit accept);
        inValid       = 1'b1;
        inPc          = pc;
        inInstr       = instr;
        {inInstMiss, inInstIllegal, inInstInvalid} = f;
        if (accept) exp_q.push_back('{pc: pc, instr: instr, flags: f});
    endtask

    task automatic idle_in();
        inValid = 1'b0;
        inPc    = '0;
        inInstr = '0;
        {inInstMiss, inInstIllegal, inInstInvalid} = 3'b000;
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [2:0] f);
        drive(pc, instr, f, 1'b1);
        step();
        idle_in();
    endtask

    task automatic drain(input int max_cycles);
        outReady = 1'b1;
        for (int i = 0; i < max_cycles && outValid; i++) step();
        outReady = 1'b0;
        chk("drain_empty", {31'd0, outValid}, 32'd0);
    endtask

    initial begin
        resetn   = 1'b0;
        expFlush = 1'b0;
        outReady = 1'b0;
        idle_in();
        #12;
        chk("rst_valid", {31'd0, outValid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, inReady}, 32'd1);
        chk("rst_pc", outPc, 32'd0);
        chk("rst_instr", outInstr, 32'd0);
        resetn = 1'b1;
        step();

        // Test 1: single push visible next cycle
        push1(32'hbfc00000, 32'h24080001, 3'b000);
        chk("t1_valid", {31'd0, outValid}, 32'd1);
        chk("t1_pc", outPc, 32'hbfc00000);
        chk("t1_instr", outInstr, 32'h24080001);
        chk("t1_count", {29'd0, count}, 32'd1);
        drain(4);

        // Test 2: fill, dropped fifth push, ordered drain
        for (int i = 0; i < 4; i++)
            push1(32'hbfc00000 + 32'(4 * i), 32'h1000 + 32'(i), 3'b000);
        chk("t2_count", {29'd0, count}, 32'd4);
        chk("t2_full", {31'd0, inReady}, 32'd0);
        drive(32'hbfc00010, 32'hdeadbeef, 3'b000, 1'b0);
        step();
        idle_in();
        chk("t2_count_hold", {29'd0, count}, 32'd4);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("t2_count_pop", {29'd0, count}, 32'd3);
        chk("t2_ready_back", {31'd0, inReady}, 32'd1);
        drain(4);

        // Test 3: steady push+pop at count 2 across pointer wrap
        push1(32'h00001000, 32'h2000, 3'b000);
        push1(32'h00001004, 32'h2001, 3'b000);
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h00001008 + 32'(4 * i), 32'h2002 + 32'(i), 3'b000, 1'b1);
            step();
            chk("t3_count", {29'd0, count}, 32'd2);
        end
        idle_in();
        outReady = 1'b0;
        drain(4);

        // Test 4: exception flags travel with their entry
        push1(32'h00400000, 32'h8c000000, 3'b100);
        push1(32'h00400004, 32'h00000000, 3'b000);
        chk("t4_miss", {31'd0, outInstMiss}, 32'd1);
        chk("t4_pc", outPc, 32'h00400000);
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        chk("t4_miss_next", {31'd0, outInstMiss}, 32'd0);
        chk("t4_pc_next", outPc, 32'h00400004);
        drain(4);
        push1(32'h00500000, 32'h11111111, 3'b011);
        drain(4);

        // Test 5: flush beats simultaneous push and pop
        for (int i = 0; i < 3; i++)
            push1(32'h00600000 + 32'(4 * i), 32'h3000 + 32'(i), 3'b000);
        drive(32'h0060000c, 32'h3003, 3'b000, 1'b0);
        expFlush = 1'b1;
        outReady = 1'b1;
        step();
        exp_q.delete();
        expFlush = 1'b0;
        outReady = 1'b0;
        idle_in();
        chk("t5_count", {29'd0, count}, 32'd0);
        chk("t5_valid", {31'd0, outValid}, 32'd0);
        chk("t5_instr", outInstr, 32'd0);
        chk("t5_ready", {31'd0, inReady}, 32'd1);
        push1(32'h00700000, 32'h4000, 3'b000);
        drain(4);

        // Test 6: asynchronous reset between clock edges
        push1(32'h00800000, 32'h5000, 3'b000);
        push1(32'h00800004, 32'h5001, 3'b000);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_valid", {31'd0, outValid}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        exp_q.delete();
        #1;
        resetn = 1'b1;
        step();
        push1(32'hbfc00000, 32'h24080001, 3'b000);
        chk("t6_head", outPc, 32'hbfc00000);
        drain(4);

        step();
        chk("leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Decoupling FIFO between the instruction-fetch stage and decode.
- Captures each fetched instruction with its PC and TLB fetch-exception flags, and presents the oldest entry to decode.
- Lets fetch keep issuing while decode is stalled. Discards all contents on an exception flush.

Parameters:
- DEPTH, 4, number of entries. Power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write pointer width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- expFlush  input  1  exception/eret flush. Empties the queue.
- inValid  input  1  fetch presents an instruction this cycle.
- inPc  input  32  PC of the presented instruction.
- inInstr  input  32  instruction word.
- inInstMiss  input  1  TLB refill exception on the fetch.
- inInstIllegal  input  1  address-error exception on the fetch.
- inInstInvalid  input  1  TLB invalid exception on the fetch.
- inReady  output  1  queue can accept a push (not full).
- outValid  output  1  head entry valid.
- outPc  output  32  head PC.
- outInstr  output  32  head instruction.
- outInstMiss  output  1  head refill flag.
- outInstIllegal  output  1  head address-error flag.
- outInstInvalid  output  1  head invalid flag.
- outReady  input  1  decode consumes the head this cycle (decode not stalled).
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset: resetn=0 asynchronously clears the pointers and count.
  - outValid=0; outPc, outInstr and the three out flags = 0; count=0; inReady=1.
  - The storage array is not reset.
- Storage: circular buffer of DEPTH entries, 67 bits each (pc, instr, 3 flags).
  - wrPtr and rdPtr are PTR_W bits wide and wrap naturally from DEPTH-1 to 0.
- Push: push = inValid & inReady & !expFlush.
  - The entry is written at wrPtr on the clock edge and wrPtr increments.
- Pop: pop = outValid & outReady & !expFlush. rdPtr increments.
- Count:
  - push & !pop: +1.
  - pop & !push: -1.
  - push & pop: unchanged.
- inReady = (count != DEPTH). Combinational from registered count.
  - No push-through when full: a simultaneous pop does not free a slot in the same cycle.
- outValid = (count != 0).
- Head outputs:
  - When outValid=1, outPc, outInstr and the flags are driven combinationally from entry[rdPtr].
  - When outValid=0, all of them are driven to 0, so decode sees a NOP (sll $0,$0,0).
- Latency: a push into an empty queue is visible at the head on the next cycle. There is no same-cycle bypass.
- Ordering: strict FIFO. Exception flags travel with their instruction unmodified.
- Flush: expFlush=1 at a clock edge sets wrPtr=rdPtr=0 and count=0.
  - A push or pop in the same cycle is ignored; flush has priority over both.
  - The cycle after the flush: outValid=0, inReady=1.
- Empty + pop attempt: no effect, since outValid=0 gates the pop.
- Full + push attempt: no effect, since inReady=0. Fetch must hold its data.
- Full + pop: count becomes DEPTH-1 and inReady rises the next cycle.
- Empty + push & outReady in the same cycle: the push is stored. No pop occurs, since outValid=0.
- Reset mid-operation: the asynchronous clear applies immediately regardless of clk. Outputs take reset values within the same cycle.
- No combinational path from inValid or outReady to inReady or outValid.

Test Plan:
1. Reset, then push PC 0xbfc00000 / instr 0x24080001 with outReady=0. Next cycle: outValid=1, outPc=0xbfc00000, outInstr=0x24080001, count=1.
2. Push 4 sequential PCs 0xbfc00000..0xbfc0000c with outReady=0. After the 4th push: count=4, inReady=0. A 5th push (PC 0xbfc00010) is dropped. Then outReady=1 for 4 cycles: the head yields 0x...00, 04, 08, 0c in order, then outValid=0.
3. Hold count=2 and drive push & pop every cycle for 8 cycles with PCs incrementing by 4. Count stays 2, pointers wrap past DEPTH-1, output order is preserved, and no entry is lost or duplicated.
4. Push an entry with inInstMiss=1, PC 0x00400000, then a clean entry. The head shows outInstMiss=1 with PC 0x00400000; after the pop, the next head shows outInstMiss=0.
5. With count=3, assert expFlush together with inValid=1 and outReady=1. Next cycle: count=0, outValid=0, outInstr=0, inReady=1, and the pushed entry is absent.
6. With count=2, pull resetn low between clock edges. outValid=0 and count=0 immediately. After release, a push of PC 0xbfc00000 is the first entry to come out.
